// File: rtl/regfile_reader_if.sv
// Register-file read port plus the tagged word stream produced by regfile_reader.
// master: the sequencer (drives rd_addr and the out_* stream).
// slave:  register file / downstream consumer side.
interface regfile_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_addr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/regfile_reader.sv
// Read-side scan sequencer for the 16x16 register file.
// Walks first_addr..last_addr (wrapping modulo 16), capturing each word at its
// LOAD cycle and presenting it as a valid/ready stream tagged with its index.
// Optional: define REGFILE_READER_CHECKSUM_EN to add a running modulo-2^DATA_W
// checksum of every transferred word of the current scan.
//
// state | meaning
// IDLE  | waiting for start; rd_addr ignored by the port mux
// LOAD  | rd_addr = counter; capture rd_data/counter at the edge
// HOLD  | out_valid high, word held until out_ready
// FIN   | done pulse for one cycle, then IDLE
module regfile_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  regfile_reader_if.master      bus,
  output logic                  busy,
  output logic                  done
`ifdef REGFILE_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addrCnt;
  logic [ADDR_W-1:0] endAddr;

  // The read port always follows the counter; outside a scan the mux ignores it.
  assign bus.rd_addr = addrCnt;

  // Scan sequencer with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addrCnt       <= '0;
      endAddr       <= '0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addrCnt <= first_addr;
            endAddr <= last_addr;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= addrCnt;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (addrCnt == endAddr) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addrCnt <= addrCnt + ADDR_W'(1);
              state   <= LOAD;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REGFILE_READER_CHECKSUM_EN
  // Running sum of transferred words; cleared on accepted start, held after the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == HOLD && bus.out_ready) begin
      checksum <= checksum + bus.out_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed scenarios plus randomized
// scans, checked against a scan model built from the register array it owns.
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic        busy;
  logic        done;
`ifdef REGFILE_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  regfile_reader_if #(.ADDR_W(4), .DATA_W(16)) bus();

  logic [15:0] regs [16];
  assign bus.rd_data = regs[bus.rd_addr];

  int nVec = 0;
  int nErr = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) doneCount <= doneCount + 1;

  regfile_reader #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
`ifdef REGFILE_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan f..l. stallWord/stallLen hold out_ready low on one word; randStall
  // adds 0..3 stall cycles per word; writeWord writes regs[wIdx]=wVal (and pulses
  // start) while that word is held; resetWord asserts reset while that word is held.
  task automatic runScan(input logic [3:0] f, input logic [3:0] l,
                         input int stallWord, input int stallLen, input bit randStall,
                         input int writeWord, input logic [3:0] wIdx, input logic [15:0] wVal,
                         input int resetWord);
    int n;
    int dc0;
    int stall;
    logic [15:0] sum;
    logic [3:0]  ea;
    logic [15:0] ed;
    n   = ((int'(l) - int'(f)) & 15) + 1;
    dc0 = doneCount;
    sum = 16'h0;
    start = 1'b1; first_addr = f; last_addr = l;
    step();
    start = 1'b0; first_addr = 4'($urandom); last_addr = 4'($urandom);
    nVec++; if (busy !== 1'b1) begin nErr++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    nVec++; if (bus.out_valid !== 1'b0) begin nErr++; $display("FAIL valid_in_load: got %b expected 0", bus.out_valid); end
    for (int k = 0; k < n; k++) begin
      ea = 4'(int'(f) + k);
      step();
      ed = regs[ea];
      nVec++; if (bus.out_valid !== 1'b1) begin nErr++; $display("FAIL valid_latency word %0d: got %b expected 1", k, bus.out_valid); end
      nVec++; if (bus.out_addr !== ea) begin nErr++; $display("FAIL out_addr word %0d: got %0d expected %0d", k, bus.out_addr, ea); end
      nVec++; if (bus.out_data !== ed) begin nErr++; $display("FAIL out_data word %0d: got %h expected %h", k, bus.out_data, ed); end
      nVec++; if (busy !== 1'b1) begin nErr++; $display("FAIL busy_hold word %0d: got %b expected 1", k, busy); end
      if (k == writeWord) begin
        regs[wIdx] = wVal;
        start = 1'b1; first_addr = 4'($urandom); last_addr = 4'($urandom);
      end
      if (k == resetWord) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        nVec++; if (bus.out_valid !== 1'b0) begin nErr++; $display("FAIL reset_mid valid: got %b expected 0", bus.out_valid); end
        nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        nVec++; if (done !== 1'b0) begin nErr++; $display("FAIL reset_mid done: got %b expected 0", done); end
        nVec++; if (bus.out_data !== 16'h0) begin nErr++; $display("FAIL reset_mid out_data: got %h expected 0", bus.out_data); end
        nVec++; if (bus.rd_addr !== 4'h0) begin nErr++; $display("FAIL reset_mid rd_addr: got %0d expected 0", bus.rd_addr); end
        step();
        nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_mid busy_after: got %b expected 0", busy); end
        nVec++; if (doneCount !== dc0) begin nErr++; $display("FAIL reset_mid done_pulses: got %0d expected %0d", doneCount - dc0, 0); end
        return;
      end
      stall = (k == stallWord) ? stallLen : (randStall ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < stall; s++) begin
        bus.out_ready = 1'b0;
        step();
        nVec++; if (bus.out_valid !== 1'b1) begin nErr++; $display("FAIL stall_valid word %0d cyc %0d: got %b expected 1", k, s, bus.out_valid); end
        nVec++; if (bus.out_addr !== ea) begin nErr++; $display("FAIL stall_addr word %0d: got %0d expected %0d", k, bus.out_addr, ea); end
        nVec++; if (bus.out_data !== ed) begin nErr++; $display("FAIL stall_data word %0d: got %h expected %h", k, bus.out_data, ed); end
      end
      start = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      sum = sum + ed;
      nVec++; if (bus.out_valid !== 1'b0) begin nErr++; $display("FAIL valid_after_xfer word %0d: got %b expected 0", k, bus.out_valid); end
      if (k < n - 1) begin
        nVec++; if (done !== 1'b0) begin nErr++; $display("FAIL early_done word %0d: got %b expected 0", k, done); end
      end else begin
        nVec++; if (done !== 1'b1) begin nErr++; $display("FAIL done_pulse: got %b expected 1", done); end
        nVec++; if (busy !== 1'b1) begin nErr++; $display("FAIL busy_in_fin: got %b expected 1", busy); end
`ifdef REGFILE_READER_CHECKSUM_EN
        nVec++; if (checksum !== sum) begin nErr++; $display("FAIL checksum: got %h expected %h", checksum, sum); end
`endif
      end
    end
    step();
    nVec++; if (done !== 1'b0) begin nErr++; $display("FAIL done_width: got %b expected 0", done); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL busy_end: got %b expected 0", busy); end
    nVec++; if (doneCount !== dc0 + 1) begin nErr++; $display("FAIL done_count: got %0d expected 1", doneCount - dc0); end
  endtask

  task automatic preloadRamp();
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; first_addr = 4'h3; last_addr = 4'h7; bus.out_ready = 1'b0;
    step(); step();
    nVec++; if (bus.out_valid !== 1'b0) begin nErr++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL rst_busy: got %b expected 0", busy); end
    nVec++; if (done !== 1'b0) begin nErr++; $display("FAIL rst_done: got %b expected 0", done); end
    nVec++; if (bus.out_data !== 16'h0) begin nErr++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
    nVec++; if (bus.out_addr !== 4'h0) begin nErr++; $display("FAIL rst_out_addr: got %0d expected 0", bus.out_addr); end
    nVec++; if (bus.rd_addr !== 4'h0) begin nErr++; $display("FAIL rst_rd_addr: got %0d expected 0", bus.rd_addr); end
`ifdef REGFILE_READER_CHECKSUM_EN
    nVec++; if (checksum !== 16'h0) begin nErr++; $display("FAIL rst_checksum: got %h expected 0", checksum); end
`endif
    reset = 1'b0;
    step(); step(); step();
    nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL idle_no_start busy: got %b expected 0", busy); end
    nVec++; if (bus.out_valid !== 1'b0) begin nErr++; $display("FAIL idle_no_start valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_full_scan();
    preloadRamp();
    runScan(4'd0, 4'd15, -1, 0, 1'b0, -1, 4'd0, 16'h0, -1);
`ifdef REGFILE_READER_CHECKSUM_EN
    nVec++; if (checksum !== 16'h0078) begin nErr++; $display("FAIL full_checksum: got %h expected 0078", checksum); end
`endif
  endtask

  task automatic test_single();
    preloadRamp();
    runScan(4'd5, 4'd5, -1, 0, 1'b0, -1, 4'd0, 16'h0, -1);
  endtask

  task automatic test_wrap();
    preloadRamp();
    runScan(4'd14, 4'd1, -1, 0, 1'b0, -1, 4'd0, 16'h0, -1);
  endtask

  task automatic test_backpressure();
    preloadRamp();
    runScan(4'd0, 4'd15, 3, 7, 1'b0, -1, 4'd0, 16'h0, -1);
  endtask

  task automatic test_snapshot();
    preloadRamp();
    runScan(4'd0, 4'd15, 2, 4, 1'b0, 2, 4'd9, 16'hBEEF, -1);
    nVec++; if (regs[9] !== 16'hBEEF) begin nErr++; $display("FAIL snapshot_model: got %h expected beef", regs[9]); end
    // Overwrite the held register itself: captured word must not change.
    preloadRamp();
    runScan(4'd0, 4'd4, 2, 3, 1'b0, 2, 4'd2, 16'hDEAD, -1);
  endtask

  task automatic test_reset_mid();
    preloadRamp();
    runScan(4'd0, 4'd15, -1, 0, 1'b0, -1, 4'd0, 16'h0, 3);
    runScan(4'd0, 4'd15, -1, 0, 1'b0, -1, 4'd0, 16'h0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
      runScan(4'($urandom), 4'($urandom), -1, 0, 1'b1,
              int'($urandom_range(0, 3)), 4'($urandom), 16'($urandom), -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    reset = 1'b1; start = 1'b0; first_addr = 4'h0; last_addr = 4'h0; bus.out_ready = 1'b0;
    test_reset();
    test_full_scan();
    test_single();
    test_wrap();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
